// File: rtl/hi_reader_sequencer_if.sv
// hi_reader_sequencer_if: ARM/datapath-facing signal bundle of the HF reader exchange sequencer.
interface hi_reader_sequencer_if;
  logic        start;
  logic [9:0]  tx_bit_count;
  logic [15:0] guard_cycles;
  logic [11:0] rx_frames;
  logic        tx_bit;
  logic        shallow;
  logic [13:0] corr_amplitude;
  logic        tx_bit_req;
  logic        mod_out;
  logic [3:0]  minor_mode;
  logic        busy;
  logic        done;
  logic        tag_seen;
  logic        timeout;
  modport master (
    output start, tx_bit_count, guard_cycles, rx_frames, tx_bit, shallow, corr_amplitude,
    input  tx_bit_req, mod_out, minor_mode, busy, done, tag_seen, timeout
  );
  modport slave (
    input  start, tx_bit_count, guard_cycles, rx_frames, tx_bit, shallow, corr_amplitude,
    output tx_bit_req, mod_out, minor_mode, busy, done, tag_seen, timeout
  );
endinterface

// File: rtl/hi_reader_sequencer.sv
// hi_reader_sequencer: sequences one HF reader exchange (TX bits, guard time, RX window) on negedge ck_1356meg.
// Optional shallow-modulation TX mode is enabled by defining HI_READER_SEQ_SHALLOW_EN.
`ifndef FPGA_HF_READER_MODE_RECEIVE_AMPLITUDE
`define FPGA_HF_READER_MODE_RECEIVE_AMPLITUDE 4'd1
`endif
`ifndef FPGA_HF_READER_MODE_SEND_FULL_MOD
`define FPGA_HF_READER_MODE_SEND_FULL_MOD 4'd3
`endif
`ifndef FPGA_HF_READER_MODE_SEND_SHALLOW_MOD
`define FPGA_HF_READER_MODE_SEND_SHALLOW_MOD 4'd4
`endif
module hi_reader_sequencer #(
  parameter int          BIT_PERIOD   = 128,
  parameter logic [13:0] AMP_THRESH   = 14'd64,
  parameter int          QUIET_FRAMES = 4
) (
  input logic ck_1356meg,
  input logic reset_n,
  hi_reader_sequencer_if.slave bus
);
  localparam int CW = BIT_PERIOD > 1 ? $clog2(BIT_PERIOD) : 1;
  localparam int QW = $clog2(QUIET_FRAMES + 1);
  typedef enum logic [2:0] {S_IDLE, S_TX, S_GUARD, S_RX, S_DONE} state_t;
  state_t r_state, w_next;
  logic [9:0]    r_tx_n, r_bits;
  logic [15:0]   r_guard_n, r_gcnt;
  logic [11:0]   r_rx_n, r_frames;
  logic [CW-1:0] r_cyc;
  logic [5:0]    r_fc;
  logic [QW-1:0] r_quiet;
  logic          r_mod, r_tag, r_timeout;
  logic          w_req, w_tx_end, w_g_end, w_bound, w_above, w_expire, w_rx_end;
  logic [QW-1:0] w_quiet_nx;
  logic [11:0]   w_frames_nx;
  logic [3:0]    w_tx_mode;
  // The cycle after the last bit period is a tail that keeps the final bit on the line before GUARD.
  assign w_req       = r_state == S_TX && r_cyc == '0 && r_bits != r_tx_n;
  assign w_tx_end    = r_cyc == '0 && r_bits == r_tx_n;
  assign w_g_end     = r_guard_n == 16'd0 || r_gcnt == r_guard_n - 16'd1;
  assign w_bound     = r_fc == 6'd63;
  assign w_above     = bus.corr_amplitude > AMP_THRESH;
  assign w_quiet_nx  = w_above ? '0 : (r_tag ? r_quiet + QW'(1) : r_quiet);
  assign w_frames_nx = r_frames + 12'd1;
  assign w_expire    = w_frames_nx == r_rx_n;
  assign w_rx_end    = w_bound && (w_quiet_nx == QW'(QUIET_FRAMES) || w_expire);
`ifdef HI_READER_SEQ_SHALLOW_EN
  logic r_shallow;
  always_ff @(negedge ck_1356meg) begin
    if (!reset_n) r_shallow <= 1'b0;
    else if (r_state == S_IDLE && bus.start) r_shallow <= bus.shallow;
  end
  assign w_tx_mode = r_shallow ? `FPGA_HF_READER_MODE_SEND_SHALLOW_MOD : `FPGA_HF_READER_MODE_SEND_FULL_MOD;
`else
  logic w_unused_shallow;
  assign w_unused_shallow = bus.shallow;
  assign w_tx_mode = `FPGA_HF_READER_MODE_SEND_FULL_MOD;
`endif
  always_ff @(negedge ck_1356meg) begin
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = bus.tx_bit_count == 10'd0 ? S_GUARD : S_TX;
      S_TX:    if (w_tx_end) w_next = S_GUARD;
      S_GUARD: if (w_g_end) w_next = r_rx_n == 12'd0 ? S_DONE : S_RX;
      S_RX:    if (w_rx_end) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(negedge ck_1356meg) begin
    if (!reset_n) begin
      r_tx_n    <= '0;
      r_guard_n <= '0;
      r_rx_n    <= '0;
      r_cyc     <= '0;
      r_bits    <= '0;
      r_gcnt    <= '0;
      r_fc      <= '0;
      r_frames  <= '0;
      r_quiet   <= '0;
      r_mod     <= 1'b0;
      r_tag     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_tx_n    <= bus.tx_bit_count;
          r_guard_n <= bus.guard_cycles;
          r_rx_n    <= bus.rx_frames;
          r_cyc     <= '0;
          r_bits    <= '0;
          r_gcnt    <= '0;
          r_fc      <= '0;
          r_frames  <= '0;
          r_quiet   <= '0;
          r_mod     <= 1'b0;
          r_tag     <= 1'b0;
          r_timeout <= 1'b0;
        end
        S_TX: if (w_tx_end) r_mod <= 1'b0;
        else begin
          if (w_req) begin
            r_mod  <= bus.tx_bit;
            r_bits <= r_bits + 10'd1;
          end
          r_cyc <= r_cyc == CW'(BIT_PERIOD - 1) ? '0 : r_cyc + CW'(1);
        end
        S_GUARD: if (!w_g_end) r_gcnt <= r_gcnt + 16'd1;
        S_RX: begin
          r_fc <= r_fc + 6'd1;
          if (w_bound) begin
            r_frames <= w_frames_nx;
            r_quiet  <= w_quiet_nx;
            if (w_above) r_tag <= 1'b1;
            if (w_expire && !r_tag && !w_above) r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  assign bus.tx_bit_req = w_req;
  assign bus.mod_out    = r_mod;
  assign bus.minor_mode = r_state == S_TX ? w_tx_mode : `FPGA_HF_READER_MODE_RECEIVE_AMPLITUDE;
  assign bus.busy       = r_state == S_TX || r_state == S_GUARD || r_state == S_RX;
  assign bus.done       = r_state == S_DONE;
  assign bus.tag_seen   = r_tag;
  assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_hi_reader_sequencer.sv
// tb_hi_reader_sequencer: directed exchanges checked every cycle against a timeline model of the exchange.
module tb_hi_reader_sequencer;
  localparam int P = 128;
  localparam logic [3:0] M_AMP = 4'd1, M_FULL = 4'd3, M_SHAL = 4'd4;
`ifdef HI_READER_SEQ_SHALLOW_EN
  localparam bit SHAL_EN = 1'b1;
`else
  localparam bit SHAL_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0, n_vec = 0, n_err = 0;
  hi_reader_sequencer_if bus();
  hi_reader_sequencer #(.BIT_PERIOD(P), .AMP_THRESH(14'd64), .QUIET_FRAMES(4)) dut (
    .ck_1356meg(clk), .reset_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) cyc++;
  // mode 0: no per-cycle checking, 1: exchange timeline from ex_start, 2: idle after reset
  int mode = 0, ex_start = 0;
  int p_txn = 0, p_T = 0, p_G = 0, p_R = 0, p_ftag = 0;
  bit p_tof = 0, p_shal = 0;
  logic [15:0] p_bits = '0;
  logic [13:0] a_base = '0, a_hi = '0;
  int a_lo_f = 0, a_hi_f = -1;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [13:0] amp_of(input int f);
    return (f >= a_lo_f && f <= a_hi_f) ? a_hi : a_base;
  endfunction
  // Frame-by-frame evaluation of the RX window rules to get window length and final flags.
  task automatic plan(input int txn, input int g, input int rxn);
    int q, f_end;
    bit tag;
    q = 0; f_end = 0; tag = 0;
    p_txn = txn; p_T = txn != 0 ? txn * P + 1 : 0; p_G = g != 0 ? g : 1;
    p_ftag = 0; p_tof = 0;
    for (int f = 1; f <= rxn && f_end == 0; f++) begin
      if (amp_of(f) > 14'd64) begin
        tag = 1; q = 0;
        if (p_ftag == 0) p_ftag = f;
      end else if (tag) q++;
      if (q == 4 || f == rxn) begin
        f_end = f; p_tof = !tag;
      end
    end
    p_R = f_end * 64;
  endtask
  int k, dc, rx0, bi;
  bit in_tx, e_busy, e_done, e_req, e_mod, e_tag, e_to;
  logic [3:0] e_minor;
  always @(posedge clk) begin
    k = cyc - ex_start;
    rx0 = p_T + p_G;
    dc = rx0 + p_R + 1;
    in_tx = mode == 1 && k >= 1 && k <= p_T;
    if (mode != 0) begin
      bi = (k - 2) / P;
      e_busy  = mode == 1 && k >= 1 && k < dc;
      e_done  = mode == 1 && k == dc;
      e_req   = in_tx && (k - 1) % P == 0 && (k - 1) / P < p_txn;
      e_mod   = in_tx && k >= 2 && bi < 16 ? p_bits[bi] : 1'b0;
      e_minor = in_tx ? ((SHAL_EN && p_shal) ? M_SHAL : M_FULL) : M_AMP;
      e_tag   = mode == 1 && p_ftag > 0 && k > rx0 + 64 * p_ftag;
      e_to    = mode == 1 && p_tof && k >= dc;
      check("busy", 32'(bus.busy), 32'(e_busy));
      check("done", 32'(bus.done), 32'(e_done));
      check("tx_bit_req", 32'(bus.tx_bit_req), 32'(e_req));
      check("mod_out", 32'(bus.mod_out), 32'(e_mod));
      check("minor_mode", 32'(bus.minor_mode), 32'(e_minor));
      check("tag_seen", 32'(bus.tag_seen), 32'(e_tag));
      check("timeout", 32'(bus.timeout), 32'(e_to));
    end
    bi = (k + P - 2) / P;
    bus.tx_bit = in_tx && bi < 16 ? p_bits[bi] : 1'b0;
    bus.corr_amplitude = mode == 1 && k > rx0 && k <= rx0 + p_R ? amp_of((k - rx0 - 1) / 64 + 1) : 14'd0;
  end
  task automatic do_start(input int txn, input logic [15:0] bits, input int g, input int rxn, input bit shal,
                          input logic [13:0] base, input logic [13:0] hi, input int lo_f, input int hi_f);
    @(posedge clk); #1;
    bus.tx_bit_count = 10'(txn);
    bus.guard_cycles = 16'(g);
    bus.rx_frames = 12'(rxn);
    bus.shallow = shal;
    a_base = base; a_hi = hi; a_lo_f = lo_f; a_hi_f = hi_f;
    p_bits = bits; p_shal = shal;
    plan(txn, g, rxn);
    ex_start = cyc;
    mode = 1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input string nm, input int exp_k, input bit exp_tag, input bit exp_to);
    int got;
    got = -1;
    for (int i = 0; i < 5000 && got < 0; i++) begin
      @(posedge clk);
      if (bus.done === 1'b1) got = cyc - ex_start;
    end
    check({nm, "_done_cycle"}, 32'(got), 32'(exp_k));
    check({nm, "_tag"}, 32'(bus.tag_seen), 32'(exp_tag));
    check({nm, "_timeout"}, 32'(bus.timeout), 32'(exp_to));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int got, seen;
    bus.start = 1'b0; bus.tx_bit_count = '0; bus.guard_cycles = '0; bus.rx_frames = '0; bus.shallow = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_mod_out", 32'(bus.mod_out), 0);
    check("rst_minor_mode", 32'(bus.minor_mode), 32'(M_AMP));
    check("rst_done", 32'(bus.done), 0);
    check("rst_tx_bit_req", 32'(bus.tx_bit_req), 0);
    check("rst_tag_seen", 32'(bus.tag_seen), 0);
    check("rst_timeout", 32'(bus.timeout), 0);
    rst_n = 1'b1;
    mode = 2;
    repeat (3) @(posedge clk);
    // TX 1,0,1 then long guard and an RX window that expires at low amplitude
    do_start(3, 16'b101, 1172, 10, 1'b0, 14'd10, 14'd0, 0, -1);
    check("model_tx_len", 32'(p_T), 32'd385);
    check("model_rx_len", 32'(p_R), 32'd640);
    got = -1;
    for (int i = 0; i < 2000 && got < 0; i++) begin
      @(posedge clk);
      if (bus.minor_mode !== M_FULL) got = cyc - ex_start;
    end
    check("guard_entry_cycle", 32'(got), 32'd386);
    wait_done("rx_timeout", 2198, 1'b0, 1'b1);
    // activity in frames 2-5, four quiet frames end the window early
    do_start(0, 16'h0, 10, 100, 1'b0, 14'd0, 14'd200, 2, 5);
    check("model_early_len", 32'(p_R), 32'd576);
    wait_done("early_exit", 587, 1'b1, 1'b0);
    // quiet exit coincides with window expiry
    do_start(0, 16'h0, 0, 9, 1'b0, 14'd0, 14'd200, 2, 5);
    wait_done("quiet_and_expiry", 578, 1'b1, 1'b0);
    // amplitude equal to threshold is not activity
    do_start(0, 16'h0, 3, 2, 1'b0, 14'd64, 14'd0, 0, -1);
    wait_done("at_threshold", 132, 1'b0, 1'b1);
    do_start(0, 16'h0, 3, 2, 1'b0, 14'd64, 14'd65, 2, 2);
    wait_done("above_on_last_frame", 132, 1'b1, 1'b0);
    // everything zero: pass-through guard, no TX, no RX
    do_start(0, 16'h0, 0, 0, 1'b0, 14'd0, 14'd0, 0, -1);
    wait_done("zero_lengths", 2, 1'b0, 1'b0);
    // shallow request, plus a start while busy that must be ignored
    do_start(1, 16'h1, 5, 0, 1'b1, 14'd0, 14'd0, 0, -1);
    check("shallow_minor_mode", 32'(bus.minor_mode), SHAL_EN ? 32'(M_SHAL) : 32'(M_FULL));
    repeat (38) @(posedge clk);
    #1;
    bus.tx_bit_count = '0; bus.guard_cycles = '0; bus.rx_frames = '0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("busy_start_ignored", 135, 1'b0, 1'b0);
    // reset in the middle of TX aborts without a done pulse
    do_start(3, 16'h7, 20, 5, 1'b0, 14'd0, 14'd0, 0, -1);
    repeat (50) @(posedge clk);
    #1;
    mode = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_mod_out", 32'(bus.mod_out), 0);
    check("abort_minor_mode", 32'(bus.minor_mode), 32'(M_AMP));
    mode = 2;
    seen = 0;
    repeat (600) begin
      @(posedge clk);
      if (bus.done === 1'b1) seen++;
    end
    check("abort_no_done", 32'(seen), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
